// File: rtl/inst_fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
package inst_fetch_pkg;

  localparam int ADDR_W    = 8;
  localparam int INST_W    = 16;
  localparam int ENTRY_W   = INST_W + ADDR_W;
  localparam int MAX_DEPTH = 4;

  localparam logic [ADDR_W-1:0] RESET_PC_DEFAULT = 8'h00;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2
  } fetch_state_t;

  function automatic logic [ADDR_W-1:0] pc_inc(input logic [ADDR_W-1:0] pc);
    return pc + 8'd1;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch buffer of {inst, pc} entries. Exposes the post-update count and
// head so the owner can register its outputs from the next-cycle view.
module fetch_fifo
  import inst_fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               push,
  input  logic [ENTRY_W-1:0] push_data,
  input  logic               pop,
  input  logic               flush,
  output logic [2:0]         count,
  output logic [2:0]         count_next,
  output logic [ENTRY_W-1:0] head_next
);

  logic [ENTRY_W-1:0] mem [MAX_DEPTH];
  logic [1:0]         rd_ptr;
  logic [1:0]         wr_ptr;
  logic [1:0]         rd_next;
  logic [1:0]         wr_next;
  logic               push_ok;
  logic               pop_ok;
  logic [2:0]         count_after_pop;

  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    return (p == 2'(DEPTH - 1)) ? 2'd0 : p + 2'd1;
  endfunction

  always_comb begin
    pop_ok          = pop && (count != 3'd0);
    count_after_pop = count - {2'b00, pop_ok};
    push_ok         = push && (count_after_pop < 3'(DEPTH));
    rd_next         = rd_ptr;
    wr_next         = wr_ptr;
    count_next      = count;
    head_next       = mem[rd_ptr];
    if (flush) begin
      rd_next    = 2'd0;
      wr_next    = 2'd0;
      count_next = 3'd0;
    end else begin
      rd_next    = pop_ok  ? ptr_inc(rd_ptr) : rd_ptr;
      wr_next    = push_ok ? ptr_inc(wr_ptr) : wr_ptr;
      count_next = count_after_pop + {2'b00, push_ok};
      // A word pushed into an otherwise empty buffer is the new head immediately.
      if (push_ok && (count_after_pop == 3'd0)) begin
        head_next = push_data;
      end else begin
        head_next = mem[rd_next];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= 2'd0;
      wr_ptr <= 2'd0;
      count  <= 3'd0;
      for (int i = 0; i < MAX_DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      rd_ptr <= rd_next;
      wr_ptr <= wr_next;
      count  <= count_next;
      if (push_ok && !flush) begin
        mem[wr_ptr] <= push_data;
      end
    end
  end

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch unit: sequential prefetch into a small buffer with
// redirect/flush handling and discard of in-flight responses.
module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int                DEPTH    = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] pc_in,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [INST_W-1:0] imem_data,
  output logic [INST_W-1:0] inst,
  output logic [ADDR_W-1:0] inst_pc,
  output logic              inst_valid,
  input  logic              inst_ready
);

  fetch_state_t       state;
  logic [ADDR_W-1:0]  fetch_pc;
  logic               push;
  logic               pop;
  logic               flush;
  logic [2:0]         count;
  logic [2:0]         count_next;
  logic [ENTRY_W-1:0] head_next;

  always_comb begin
    flush = redirect;
    push  = (state == FETCH) && imem_req && imem_ack && !redirect;
    pop   = inst_valid && inst_ready && !redirect;
  end

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (push),
    .push_data  ({imem_data, imem_addr}),
    .pop        (pop),
    .flush      (flush),
    .count      (count),
    .count_next (count_next),
    .head_next  (head_next)
  );

  // In DRAIN, fetch_pc already holds the redirect target while imem_addr keeps the stale address.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      imem_req  <= 1'b0;
      imem_addr <= RESET_PC;
      fetch_pc  <= RESET_PC;
    end else begin
      case (state)
        IDLE: begin
          if (redirect) begin
            fetch_pc  <= pc_in;
            imem_addr <= pc_in;
            imem_req  <= 1'b1;
            state     <= FETCH;
          end else if (count < 3'(DEPTH)) begin
            imem_addr <= fetch_pc;
            imem_req  <= 1'b1;
            state     <= FETCH;
          end else begin
            imem_req <= 1'b0;
          end
        end
        FETCH: begin
          if (redirect && imem_ack) begin
            fetch_pc  <= pc_in;
            imem_addr <= pc_in;
          end else if (redirect) begin
            fetch_pc <= pc_in;
            state    <= DRAIN;
          end else if (imem_ack) begin
            fetch_pc  <= pc_inc(fetch_pc);
            imem_addr <= pc_inc(fetch_pc);
            if (count_next >= 3'(DEPTH)) begin
              imem_req <= 1'b0;
              state    <= IDLE;
            end
          end else begin
            imem_req <= 1'b1;
          end
        end
        DRAIN: begin
          if (imem_ack) begin
            fetch_pc  <= redirect ? pc_in : fetch_pc;
            imem_addr <= redirect ? pc_in : fetch_pc;
            state     <= FETCH;
          end else if (redirect) begin
            fetch_pc <= pc_in;
          end else begin
            imem_req <= 1'b1;
          end
        end
        default: begin
          state    <= IDLE;
          imem_req <= 1'b0;
        end
      endcase
    end
  end

  // Presented instruction mirrors the buffer head after this cycle's push/pop/flush.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inst_valid <= 1'b0;
      inst       <= 16'h0000;
      inst_pc    <= 8'h00;
    end else begin
      inst_valid <= (count_next != 3'd0);
      if (count_next != 3'd0) begin
        inst    <= head_next[ENTRY_W-1:ADDR_W];
        inst_pc <= head_next[ADDR_W-1:0];
      end else begin
        inst    <= inst;
        inst_pc <= inst_pc;
      end
    end
  end

endmodule

// File: tb/tb_inst_fetch.sv
// Directed and randomized checks of inst_fetch against a queue-based
// transaction model: accepted words must appear in order, contiguous from each redirect target.
module tb_inst_fetch;

  localparam int TB_DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        redirect;
  logic [7:0]  pc_in;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic        imem_ack;
  logic [15:0] imem_data;
  logic [15:0] inst;
  logic [7:0]  inst_pc;
  logic        inst_valid;
  logic        inst_ready;

  logic [15:0] mem_arr [256];
  assign imem_data = mem_arr[imem_addr];

  inst_fetch #(.RESET_PC(8'h00), .DEPTH(TB_DEPTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .redirect   (redirect),
    .pc_in      (pc_in),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_data  (imem_data),
    .inst       (inst),
    .inst_pc    (inst_pc),
    .inst_valid (inst_valid),
    .inst_ready (inst_ready)
  );

  always #5 clk = ~clk;

  int          vectors = 0;
  int          miscompares = 0;
  int          pops_total = 0;
  logic [23:0] q[$];
  logic [7:0]  exp_fetch;
  logic        stale;
  logic [23:0] last_word;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock cycle: update the model from the inputs in force, then compare after the edge.
  task automatic tick();
    logic        pre_req;
    logic        acc;
    logic [7:0]  pre_addr;
    logic [15:0] pre_data;
    #2;
    pre_req  = imem_req;
    pre_addr = imem_addr;
    pre_data = imem_data;
    acc      = 1'b0;
    if (pre_req && imem_ack) begin
      if (redirect || stale) begin
        stale = 1'b0;
      end else begin
        chk("fetch_addr", 32'(pre_addr), 32'(exp_fetch));
        acc = 1'b1;
      end
    end
    if (redirect) begin
      q.delete();
      exp_fetch = pc_in;
      if (pre_req && !imem_ack) stale = 1'b1;
    end else begin
      if (q.size() > 0 && inst_ready) begin
        void'(q.pop_front());
        pops_total++;
      end
      if (acc) begin
        q.push_back({pre_data, exp_fetch});
        exp_fetch = exp_fetch + 8'd1;
      end
    end
    @(posedge clk);
    #1;
    chk("inst_valid", 32'(inst_valid), 32'(q.size() != 0));
    if (q.size() != 0) last_word = q[0];
    chk("inst_word", 32'({inst, inst_pc}), 32'(last_word));
    if (pre_req && !imem_ack) begin
      chk("req_hold", 32'(imem_req), 32'd1);
      chk("addr_hold", 32'(imem_addr), 32'(pre_addr));
    end
    chk("occupancy", 32'(q.size() <= TB_DEPTH), 32'd1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_addr", 32'(imem_addr), 32'h00);
    chk("rst_valid", 32'(inst_valid), 32'd0);
    chk("rst_inst", 32'(inst), 32'h0000);
    chk("rst_pc", 32'(inst_pc), 32'h00);
    q.delete();
    exp_fetch = 8'h00;
    stale     = 1'b0;
    last_word = 24'h0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic wait_req(input string tag);
    int n = 0;
    while (!imem_req && n < 3) begin
      tick();
      n++;
    end
    chk(tag, 32'(imem_req), 32'd1);
  endtask

  initial begin
    logic [7:0] wrap_seq [3];
    wrap_seq = '{8'hFE, 8'hFF, 8'h00};
    for (int i = 0; i < 256; i++) mem_arr[i] = 16'($urandom);
    redirect   = 1'b0;
    pc_in      = 8'h00;
    imem_ack   = 1'b0;
    inst_ready = 1'b0;
    #2;
    do_reset();

    // Zero-wait memory, always-ready consumer: sequential addresses and pcs.
    imem_ack   = 1'b1;
    inst_ready = 1'b1;
    wait_req("first_req");
    for (int i = 0; i < 6; i++) begin
      chk("seq_addr", 32'(imem_addr), 32'(i));
      tick();
      chk("seq_pc", 32'(inst_pc), 32'(i));
    end

    // Backpressure fills the buffer, then fetch resumes after one pop.
    do_reset();
    imem_ack   = 1'b1;
    inst_ready = 1'b0;
    wait_req("bp_req");
    chk("bp_addr0", 32'(imem_addr), 32'h00);
    tick();
    tick();
    chk("bp_req_low", 32'(imem_req), 32'd0);
    chk("bp_valid", 32'(inst_valid), 32'd1);
    chk("bp_pc", 32'(inst_pc), 32'h00);
    tick();
    chk("bp_still_idle", 32'(imem_req), 32'd0);
    imem_ack   = 1'b0;
    inst_ready = 1'b1;
    tick();
    chk("bp_pop_pc", 32'(inst_pc), 32'h01);
    inst_ready = 1'b0;
    tick();
    chk("bp_resume_req", 32'(imem_req), 32'd1);
    chk("bp_resume_addr", 32'(imem_addr), 32'h02);

    // Address wrap from FE through 00.
    redirect   = 1'b1;
    pc_in      = 8'hFE;
    inst_ready = 1'b1;
    tick();
    redirect = 1'b0;
    chk("wrap_drain_addr", 32'(imem_addr), 32'h02);
    imem_ack = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) begin
      chk("wrap_addr", 32'(imem_addr), 32'(wrap_seq[i]));
      tick();
      chk("wrap_pc", 32'(inst_pc), 32'(wrap_seq[i]));
    end

    // Redirect while a request to 05 waits three cycles.
    imem_ack = 1'b0;
    redirect = 1'b1;
    pc_in    = 8'h05;
    tick();
    redirect = 1'b0;
    imem_ack = 1'b1;
    tick();
    imem_ack = 1'b0;
    chk("wait_addr", 32'(imem_addr), 32'h05);
    tick();
    redirect = 1'b1;
    pc_in    = 8'h40;
    tick();
    redirect = 1'b0;
    tick();
    chk("drain_req", 32'(imem_req), 32'd1);
    chk("drain_addr", 32'(imem_addr), 32'h05);
    imem_ack = 1'b1;
    tick();
    chk("drain_valid", 32'(inst_valid), 32'd0);
    chk("drain_next_addr", 32'(imem_addr), 32'h40);
    tick();
    chk("drain_first_pc", 32'(inst_pc), 32'h40);

    // Redirect coincident with ack and pop.
    chk("coinc_pre_valid", 32'(inst_valid), 32'd1);
    redirect = 1'b1;
    pc_in    = 8'h80;
    tick();
    redirect = 1'b0;
    chk("coinc_valid", 32'(inst_valid), 32'd0);
    chk("coinc_addr", 32'(imem_addr), 32'h80);
    chk("coinc_req", 32'(imem_req), 32'd1);
    tick();
    chk("coinc_pc", 32'(inst_pc), 32'h80);

    // Reset during an outstanding request; a late ack must be ignored.
    imem_ack = 1'b0;
    tick();
    chk("mid_req", 32'(imem_req), 32'd1);
    #2;
    imem_ack = 1'b1;
    do_reset();
    wait_req("restart_req");
    chk("restart_addr", 32'(imem_addr), 32'h00);
    tick();
    chk("restart_pc", 32'(inst_pc), 32'h00);

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) do_reset();
      redirect   = ($urandom_range(0, 99) < 4);
      pc_in      = 8'($urandom);
      imem_ack   = ($urandom_range(0, 99) < 55);
      inst_ready = ($urandom_range(0, 99) < 60);
      tick();
    end
    chk("liveness", 32'(pops_total > 300), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
